// File: rtl/ram_rd_fetch_if.sv
// Bus bundle between the executor/CPU side, the vector RAM and the TAP shifter
// for the RAM read-fetch block.
interface ram_rd_fetch_if;
   logic        start;
   logic        abort;
   logic [23:0] start_adr;
   logic [23:0] len;
   logic [23:0] ram_adr;
   logic        ram_rd_n;
   logic [7:0]  d_ram_drv;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        busy;
   logic        done;

   modport master (
      output start, abort, start_adr, len, d_ram_drv, dout_ready,
      input  ram_adr, ram_rd_n, dout, dout_valid, busy, done
   );

   modport slave (
      input  start, abort, start_adr, len, d_ram_drv, dout_ready,
      output ram_adr, ram_rd_n, dout, dout_valid, busy, done
   );
endinterface

// File: rtl/ram_rd_fetch.sv
// Sequential byte fetcher from vector RAM into a small FIFO feeding the TAP
// shifter over valid/ready; at most one RAM read is outstanding at a time.
module ram_rd_fetch #(
   parameter int RAM_WAIT   = 2,
   parameter int FIFO_DEPTH = 2
) (
   input  logic           clk_cpu,
   input  logic           reset,
   ram_rd_fetch_if.slave  bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOVER, DRAIN} state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [23:0]   cur_adr_r;
   logic [23:0]   remaining_r;
   logic [23:0]   ram_adr_r;
   logic          ram_rd_n_r;
   logic [2:0]    wait_cnt_r;
   logic          busy_r;
   logic          done_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;

   logic space_s;
   logic pop_s;
   logic empty_after_s;
   logic accept_s;
   logic zero_len_s;
   logic issue_s;
   logic push_s;
   logic finish_s;
   logic flush_s;

   // Nothing is in flight whenever a read may be issued, so occupancy alone decides.
   assign space_s       = (count_r < DEPTH_C);
   assign pop_s         = (count_r != (PW+1)'(0)) && bus.dout_ready;
   assign empty_after_s = (count_r == (PW+1)'(0)) || ((count_r == (PW+1)'(1)) && pop_s);

   // State register
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      zero_len_s  = 1'b0;
      issue_s     = 1'b0;
      push_s      = 1'b0;
      finish_s    = 1'b0;
      flush_s     = 1'b0;
      if (bus.abort) begin
         flush_s     = 1'b1;
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if (bus.len == 24'h000000) begin
                     zero_len_s = 1'b1;
                  end else begin
                     accept_s    = 1'b1;
                     state_nxt_s = ISSUE;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            ISSUE: begin
               if (space_s) begin
                  issue_s     = 1'b1;
                  state_nxt_s = WAIT;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end
            WAIT: begin
               if (wait_cnt_r == 3'd0) begin
                  push_s      = 1'b1;
                  state_nxt_s = RECOVER;
               end else begin
                  state_nxt_s = WAIT;
               end
            end
            RECOVER: begin
               // Issuing straight from RECOVER gives one byte per RAM_WAIT+2 cycles.
               if (remaining_r == 24'h000000) begin
                  if (empty_after_s) begin
                     finish_s    = 1'b1;
                     state_nxt_s = IDLE;
                  end else begin
                     state_nxt_s = DRAIN;
                  end
               end else if (space_s) begin
                  issue_s     = 1'b1;
                  state_nxt_s = WAIT;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end
            DRAIN: begin
               if (empty_after_s) begin
                  finish_s    = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = DRAIN;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // RAM interface, address/length counters and status flags
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         cur_adr_r   <= 24'h000000;
         remaining_r <= 24'h000000;
         ram_adr_r   <= 24'h000000;
         ram_rd_n_r  <= 1'b1;
         wait_cnt_r  <= 3'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= zero_len_s | finish_s;
         if (accept_s) begin
            cur_adr_r   <= bus.start_adr;
            remaining_r <= bus.len;
         end else if (push_s) begin
            cur_adr_r   <= cur_adr_r + 24'd1;
            remaining_r <= remaining_r - 24'd1;
         end
         if (issue_s) begin
            ram_adr_r  <= cur_adr_r;
            ram_rd_n_r <= 1'b0;
            wait_cnt_r <= 3'(RAM_WAIT);
         end else if (push_s || flush_s) begin
            ram_rd_n_r <= 1'b1;
         end else if ((state_r == WAIT) && (wait_cnt_r != 3'd0)) begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
         end
         if (accept_s) begin
            busy_r <= 1'b1;
         end else if (finish_s || flush_s) begin
            busy_r <= 1'b0;
         end
      end
   end

   // Byte FIFO; simultaneous push and pop keep occupancy unchanged
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush_s) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= bus.d_ram_drv;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + (PW+1)'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - (PW+1)'(1);
         end
      end
   end

   assign bus.ram_adr    = ram_adr_r;
   assign bus.ram_rd_n   = ram_rd_n_r;
   assign bus.dout       = mem_r[rd_ptr_r];
   assign bus.dout_valid = (count_r != (PW+1)'(0));
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_ram_rd_fetch.sv
// Directed, table-driven bench for ram_rd_fetch; the RAM model returns the
// inverted low address byte so every fetched byte can be predicted.
module tb_ram_rd_fetch;

   localparam int RAM_WAIT   = 2;
   localparam int FIFO_DEPTH = 2;

   typedef struct {
      logic [23:0] adr;
      logic [23:0] n;
      int          mode;       // 0 ready, 1 toggling ready, 2 stall 40 cycles, 3 ready + start while busy
      logic [7:0]  exp_first;
      logic [23:0] exp_last;
   } vec_t;

   logic clk_cpu = 1'b0;
   logic reset   = 1'b0;
   int   n_chk   = 0;
   int   n_pass  = 0;
   vec_t vecs [4];

   ram_rd_fetch_if bus ();

   ram_rd_fetch #(.RAM_WAIT(RAM_WAIT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_cpu (clk_cpu),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_cpu = ~clk_cpu;

   assign bus.d_ram_drv = ~bus.ram_adr[7:0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_fetch(input logic [23:0] adr, input logic [23:0] n, input int mode,
                            input logic [7:0] exp_first, input logic [23:0] exp_last);
      logic [23:0] rd_adr [$];
      int          rd_idx [$];
      logic [7:0]  got [$];
      logic [23:0] a;
      int          first_valid = -1;
      int          done_idx = -1;
      int          last_pop = -1;
      int          n_done = 0;
      logic        prev_rd_n = 1'b1;
      logic        prev_valid = 1'b0;
      logic        prev_ready = 1'b0;
      logic [7:0]  prev_dout = 8'h00;
      logic        stable_ok = 1'b1;
      logic        ready;
      @(negedge clk_cpu);
      bus.start_adr  = adr;
      bus.len        = n;
      bus.start      = 1'b1;
      bus.dout_ready = (mode != 2);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_cpu);
         bus.start = (mode == 3 && i == 5);
         if (mode == 3 && i == 5) begin
            bus.start_adr = 24'h000700;
            bus.len       = 24'd8;
         end
         if (prev_rd_n && !bus.ram_rd_n) begin
            rd_adr.push_back(bus.ram_adr);
            rd_idx.push_back(i);
         end
         prev_rd_n = bus.ram_rd_n;
         if (bus.dout_valid && first_valid < 0) first_valid = i;
         if (prev_valid && !prev_ready && (bus.dout_valid !== 1'b1 || bus.dout !== prev_dout)) stable_ok = 1'b0;
         if (bus.done === 1'b1) begin
            n_done++;
            if (done_idx < 0) begin
               done_idx = i;
               check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
         end
         if (mode == 2 && i == 40) begin
            check("stall_reads", rd_adr.size(), FIFO_DEPTH);
            check("stall_rd_n", {31'd0, bus.ram_rd_n}, 32'd1);
         end
         if (mode == 1)      ready = i[0];
         else if (mode == 2) ready = (i >= 40);
         else                ready = 1'b1;
         bus.dout_ready = ready;
         if (bus.dout_valid && ready) begin
            got.push_back(bus.dout);
            last_pop = i;
         end
         prev_valid = bus.dout_valid;
         prev_ready = ready;
         prev_dout  = bus.dout;
         if (done_idx >= 0 && i >= done_idx + 3) break;
      end
      check("read_count", rd_adr.size(), 32'(n));
      check("pop_count", got.size(), 32'(n));
      if (got.size() > 0) check("first_byte", {24'd0, got[0]}, {24'd0, exp_first});
      if (rd_adr.size() > 0) check("last_adr", {8'd0, rd_adr[$]}, {8'd0, exp_last});
      for (int j = 0; j < got.size(); j++) begin
         a = adr + 24'(j);
         check("byte_seq", {24'd0, got[j]}, {24'd0, ~a[7:0]});
      end
      for (int j = 0; j < rd_adr.size(); j++) begin
         a = adr + 24'(j);
         check("adr_seq", {8'd0, rd_adr[j]}, {8'd0, a});
      end
      check("done_count", n_done, 32'd1);
      check("done_after_pop", done_idx, last_pop + 1);
      check("hold_stable", {31'd0, stable_ok}, 32'd1);
      if ((mode == 0 || mode == 3) && rd_idx.size() >= 2) begin
         check("first_valid_lat", first_valid, 2 + RAM_WAIT);
         check("first_read_lat", rd_idx[0], 32'd1);
         check("read_period", rd_idx[1] - rd_idx[0], RAM_WAIT + 2);
      end
      bus.dout_ready = 1'b0;
   endtask

   initial begin
      int   falls;
      int   n_done;
      logic saw_busy;
      logic saw_rd;
      vecs[0] = '{adr: 24'h000100, n: 24'd4, mode: 0, exp_first: 8'hFF, exp_last: 24'h000103};
      vecs[1] = '{adr: 24'hFFFFFE, n: 24'd3, mode: 0, exp_first: 8'h01, exp_last: 24'h000000};
      vecs[2] = '{adr: 24'h0000F0, n: 24'd3, mode: 1, exp_first: 8'h0F, exp_last: 24'h0000F2};
      vecs[3] = '{adr: 24'h000200, n: 24'd5, mode: 2, exp_first: 8'hFF, exp_last: 24'h000204};

      bus.start = 1'b0; bus.abort = 1'b0; bus.start_adr = 24'h0; bus.len = 24'h0; bus.dout_ready = 1'b0;
      #22;
      check("rst_ram_adr", {8'd0, bus.ram_adr}, 32'd0);
      check("rst_ram_rd_n", {31'd0, bus.ram_rd_n}, 32'd1);
      check("rst_dout", {24'd0, bus.dout}, 32'd0);
      check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk_cpu);
      reset = 1'b1;
      repeat (2) @(negedge clk_cpu);

      // zero-length request
      bus.start_adr = 24'h000123; bus.len = 24'd0; bus.start = 1'b1;
      n_done = 0; saw_busy = 1'b0; saw_rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_cpu);
         bus.start = 1'b0;
         if (bus.done) n_done++;
         if (bus.busy) saw_busy = 1'b1;
         if (!bus.ram_rd_n) saw_rd = 1'b1;
      end
      check("len0_done", n_done, 32'd1);
      check("len0_busy", {31'd0, saw_busy}, 32'd0);
      check("len0_read", {31'd0, saw_rd}, 32'd0);

      for (int v = 0; v < 4; v++) run_fetch(vecs[v].adr, vecs[v].n, vecs[v].mode, vecs[v].exp_first, vecs[v].exp_last);

      // abort in WAIT of the second byte
      @(negedge clk_cpu);
      bus.start_adr = 24'h000300; bus.len = 24'd4; bus.start = 1'b1; bus.dout_ready = 1'b0;
      falls = 0; saw_rd = 1'b1;
      for (int i = 0; i < 50 && falls < 2; i++) begin
         @(negedge clk_cpu);
         bus.start = 1'b0;
         if (saw_rd && !bus.ram_rd_n) falls++;
         saw_rd = bus.ram_rd_n;
      end
      check("abort_second_read", falls, 32'd2);
      bus.abort = 1'b1;
      @(negedge clk_cpu);
      bus.abort = 1'b0;
      check("abort_rd_n", {31'd0, bus.ram_rd_n}, 32'd1);
      check("abort_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      n_done = (bus.done === 1'b1) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_cpu);
         if (bus.done) n_done++;
      end
      check("abort_no_done", n_done, 32'd0);
      run_fetch(24'h000400, 24'd2, 0, 8'hFF, 24'h000401);

      // abort and start together
      @(negedge clk_cpu);
      bus.start_adr = 24'h000500; bus.len = 24'd2; bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk_cpu);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("abort_start_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk_cpu);
      check("abort_start_rd_n", {31'd0, bus.ram_rd_n}, 32'd1);

      // asynchronous reset in the middle of WAIT
      bus.start_adr = 24'h000580; bus.len = 24'd3; bus.start = 1'b1; bus.dout_ready = 1'b1;
      @(negedge clk_cpu);
      bus.start = 1'b0;
      @(negedge clk_cpu);
      check("prereset_rd_n", {31'd0, bus.ram_rd_n}, 32'd0);
      #3 reset = 1'b0;
      #1;
      check("areset_rd_n", {31'd0, bus.ram_rd_n}, 32'd1);
      check("areset_adr", {8'd0, bus.ram_adr}, 32'd0);
      check("areset_busy", {31'd0, bus.busy}, 32'd0);
      check("areset_valid", {31'd0, bus.dout_valid}, 32'd0);
      @(negedge clk_cpu);
      reset = 1'b1;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_cpu);
         if (bus.done) n_done++;
      end
      check("areset_no_done", n_done, 32'd0);

      // start while busy with a new len must not disturb the running fetch
      run_fetch(24'h000600, 24'd3, 3, 8'hFF, 24'h000602);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
